// File: rtl/tlp_pkg.sv
// Shared constants for the TLP lane FIFOs and the downstream flow-control FSM.
package tlp_pkg;

    localparam int TLP_DATA_W    = 10;
    localparam int TLP_ADDR_W    = 3;
    localparam int TLP_DEPTH     = 2 ** TLP_ADDR_W;
    localparam int TLP_PAUSE_DEF = 6;
    localparam int TLP_CONT_DEF  = 2;
    localparam int TLP_NUM_LANES = 4;

endpackage

// File: rtl/fifo_mem_2p.sv
// Register-array storage with one write port and one registered read port.
module fifo_mem_2p #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [DATA_W-1:0] rdata_reg;

    // Array is deliberately left without reset so it can map onto plain storage.
    always_ff @(posedge clk) begin
        if (we)
            mem_reg[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rdata_reg <= '0;
        else if (clr)
            rdata_reg <= '0;
        else if (re)
            rdata_reg <= mem_reg[raddr];
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/fifo_flow_ctrl.sv
// Single-lane TLP FIFO with watermark-driven pause/continue and sticky overflow flag.
module fifo_flow_ctrl
    import tlp_pkg::*;
#(
    parameter int DATA_W    = TLP_DATA_W,
    parameter int ADDR_W    = TLP_ADDR_W,
    parameter int PAUSE_DEF = TLP_PAUSE_DEF,
    parameter int CONT_DEF  = TLP_CONT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [ADDR_W:0]   umbral_alto,
    input  logic [ADDR_W:0]   umbral_bajo,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              fifo_pause,
    output logic              fifo_continue,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              fifo_error
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] HI_DEF  = (ADDR_W+1)'(PAUSE_DEF);
    localparam logic [ADDR_W:0] LO_DEF  = (ADDR_W+1)'(CONT_DEF);

    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic [ADDR_W:0]   hi_mark_reg;
    logic [ADDR_W:0]   lo_mark_reg;
    logic              valid_reg;
    logic              error_reg;

    logic rd_acc;
    logic wr_acc;
    logic overflow;

    // A full FIFO still accepts a write when a read frees the slot on the same edge.
    assign rd_acc   = rd_en && (count_reg != '0) && !init;
    assign wr_acc   = wr_en && ((count_reg != DEPTH_C) || rd_acc) && !init;
    assign overflow = wr_en && (count_reg == DEPTH_C) && !rd_acc && !init;

    always_comb begin
        count_next = count_reg;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            error_reg   <= 1'b0;
            hi_mark_reg <= HI_DEF;
            lo_mark_reg <= LO_DEF;
        end else if (init) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            valid_reg   <= 1'b0;
            error_reg   <= 1'b0;
            hi_mark_reg <= umbral_alto;
            lo_mark_reg <= umbral_bajo;
        end else begin
            if (wr_acc)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (rd_acc)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_next;
            valid_reg <= rd_acc;
            if (overflow)
                error_reg <= 1'b1;
        end
    end

    fifo_mem_2p #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_mem (
        .clk  (clk),
        .reset(reset),
        .clr  (init),
        .we   (wr_acc),
        .waddr(wr_ptr_reg),
        .wdata(data_in),
        .re   (rd_acc),
        .raddr(rd_ptr_reg),
        .rdata(data_out)
    );

    // Flags decode registered state only, so they are stable for the whole cycle.
    assign valid_out     = valid_reg;
    assign fifo_error    = error_reg;
    assign fifo_empty    = (count_reg == '0);
    assign fifo_full     = (count_reg == DEPTH_C);
    assign fifo_pause    = (count_reg >= hi_mark_reg);
    assign fifo_continue = (count_reg <= lo_mark_reg);

endmodule

// File: tb/tb_fifo_flow_ctrl.sv
// Directed self-checking bench for fifo_flow_ctrl.
module tb_fifo_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [3:0] umbral_alto;
    logic [3:0] umbral_bajo;
    logic       wr_en;
    logic [9:0] data_in;
    logic       rd_en;
    logic [9:0] data_out;
    logic       valid_out;
    logic       fifo_pause;
    logic       fifo_continue;
    logic       fifo_empty;
    logic       fifo_full;
    logic       fifo_error;

    int checks = 0;
    int errors = 0;

    fifo_flow_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .init         (init),
        .umbral_alto  (umbral_alto),
        .umbral_bajo  (umbral_bajo),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .fifo_pause   (fifo_pause),
        .fifo_continue(fifo_continue),
        .fifo_empty   (fifo_empty),
        .fifo_full    (fifo_full),
        .fifo_error   (fifo_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic e, input logic f,
                         input logic p, input logic c, input logic er);
        check({tag, ".empty"},    32'(fifo_empty),    32'(e));
        check({tag, ".full"},     32'(fifo_full),     32'(f));
        check({tag, ".pause"},    32'(fifo_pause),    32'(p));
        check({tag, ".continue"}, 32'(fifo_continue), 32'(c));
        check({tag, ".error"},    32'(fifo_error),    32'(er));
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; umbral_alto = 4'd6; umbral_bajo = 4'd2;
        wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

        // Reset then idle
        repeat (2) step();
        flags("rst_hold", 1, 0, 0, 1, 0);
        reset = 1'b0;
        step();
        flags("idle", 1, 0, 0, 1, 0);
        check("idle.valid", 32'(valid_out), 0);
        $display("reset/idle checked");

        // Fill 0x001..0x008 with default watermarks 6/2
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; data_in = 10'(i);
            step();
            flags($sformatf("fill%0d", i), 0, (i == 8), (i >= 6), (i <= 2), 0);
            $display("write %03h", i);
        end

        // Overflow write must be dropped and latch the error
        data_in = 10'h3FF;
        step();
        wr_en = 1'b0;
        flags("ovf", 0, 1, 1, 0, 1);
        step();
        check("ovf.sticky", 32'(fifo_error), 1);
        $display("overflow write 3ff");

        // Drain: 1-cycle latency, original order, 0x3FF never appears
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            check($sformatf("drain%0d.valid", i), 32'(valid_out), 1);
            check($sformatf("drain%0d.data", i),  32'(data_out),  32'(i));
            $display("read %03h", data_out);
        end
        step();
        check("underflow.valid", 32'(valid_out), 0);
        check("underflow.data",  32'(data_out),  8);
        rd_en = 1'b0;
        flags("drained", 1, 0, 0, 1, 1);

        // Re-init with defaults clears the sticky error
        init = 1'b1; umbral_alto = 4'd6; umbral_bajo = 4'd2;
        step();
        init = 1'b0;
        flags("init1", 1, 0, 0, 1, 0);
        check("init1.data", 32'(data_out), 0);

        // Fill again, then simultaneous read/write while full
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = 10'(16 + i);
            step();
        end
        check("refill.full", 32'(fifo_full), 1);
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 10'(32 + k);
            step();
            check($sformatf("rw%0d.data", k),  32'(data_out),  32'(16 + k));
            check($sformatf("rw%0d.valid", k), 32'(valid_out), 1);
            flags($sformatf("rw%0d", k), 0, 1, 1, 0, 0);
            $display("rw write %03h read %03h", 32 + k, data_out);
        end
        wr_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("drain2_%0d", k), 32'(data_out), (k < 4) ? 32'(20 + k) : 32'(32 + k - 4));
            $display("read %03h", data_out);
        end
        rd_en = 1'b0;
        step();
        flags("drained2", 1, 0, 0, 1, 0);

        // Empty with both enables: write wins, no bypass
        wr_en = 1'b1; rd_en = 1'b1; data_in = 10'h055;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        check("emptyrw.valid", 32'(valid_out), 0);
        flags("emptyrw", 0, 0, 0, 1, 0);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("emptyrw.rd", 32'(data_out), 32'h055);
        check("emptyrw.empty", 32'(fifo_empty), 1);
        $display("empty rw: read %03h", data_out);

        // Init mid-stream with watermarks 4/1, overriding a pending write
        wr_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            data_in = 10'(64 + i);
            step();
        end
        init = 1'b1; umbral_alto = 4'd4; umbral_bajo = 4'd1;
        step();
        init = 1'b0;
        flags("init2", 1, 0, 0, 1, 0);
        check("init2.valid", 32'(valid_out), 0);
        for (int i = 1; i <= 4; i++) begin
            data_in = 10'(48 + i);
            step();
            flags($sformatf("w4_%0d", i), 0, 0, (i >= 4), (i <= 1), 0);
        end
        wr_en = 1'b0; rd_en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("r3_%0d.data", i), 32'(data_out), 32'(48 + i));
            flags($sformatf("r3_%0d", i), 0, 0, 0, (i == 3), 0);
            $display("read %03h", data_out);
        end
        step();
        rd_en = 1'b0;
        check("r4.data", 32'(data_out), 32'd52);

        // Interleaved write/read pairs across pointer wrap
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; data_in = 10'(256 + i * 7);
            step();
            wr_en = 1'b0; rd_en = 1'b1;
            step();
            rd_en = 1'b0;
            check($sformatf("wrap%0d", i), 32'(data_out), 32'(256 + i * 7));
            $display("wrap pair %0d read %03h", i, data_out);
        end

        // Bring count to 5 with a fresh read, then assert reset between edges
        wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data_in = 10'(512 + i);
            step();
        end
        wr_en = 1'b0; rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        check("pre_rst.valid", 32'(valid_out), 1);
        check("pre_rst.data",  32'(data_out),  32'd512);
        check("pre_rst.pause", 32'(fifo_pause), 1);
        #2 reset = 1'b1;
        #1;
        flags("async_rst", 1, 0, 0, 1, 0);
        check("async_rst.valid", 32'(valid_out), 0);
        check("async_rst.data",  32'(data_out),  0);
        $display("async reset at count 5");
        step();
        reset = 1'b0;

        // Reset restores default watermarks (pause at 6, not 4)
        wr_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data_in = 10'(i);
            step();
            check($sformatf("post_rst%0d.pause", i), 32'(fifo_pause), 32'(i >= 6));
        end
        wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_flow_ctrl.md
Name: fifo_flow_ctrl

Overview:
- Single-channel TLP buffer FIFO with flow-control status flags.
- Four instances sit directly upstream of the flow-control FSM and drive its per-lane pause, continue, empty, full and error inputs.
- Stores TLP words and raises pause/continue from programmable high/low watermarks.
- Flags an overflow error when a write arrives while the FIFO is full.

Parameters:
- DATA_W, 10, width of one stored word.
- ADDR_W, 3, pointer width; DEPTH = 2**ADDR_W = 8 entries.
- PAUSE_DEF, 6, default high watermark after reset.
- CONT_DEF, 2, default low watermark after reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- init  in  1  synchronous re-initialise; latches thresholds.
- umbral_alto  in  ADDR_W+1  high watermark, sampled only while init=1.
- umbral_bajo  in  ADDR_W+1  low watermark, sampled only while init=1.
- wr_en  in  1  push data_in this cycle.
- data_in  in  DATA_W  write data.
- rd_en  in  1  pop one word this cycle.
- data_out  out  DATA_W  registered read data.
- valid_out  out  1  data_out holds a word popped on the previous edge.
- fifo_pause  out  1  occupancy >= high watermark.
- fifo_continue  out  1  occupancy <= low watermark.
- fifo_empty  out  1  occupancy == 0.
- fifo_full  out  1  occupancy == DEPTH.
- fifo_error  out  1  sticky overflow flag.

Behaviour:
- Storage: DEPTH x DATA_W register array.
  - wr_ptr and rd_ptr are ADDR_W bits wide and wrap modulo DEPTH naturally.
  - count is ADDR_W+1 bits wide, range 0..DEPTH.
- Reset, asynchronous:
  - Pointers, count, data_out and valid_out go to 0; fifo_error goes to 0.
  - Watermark registers load PAUSE_DEF and CONT_DEF.
  - Output values during and after reset: fifo_empty=1, fifo_full=0, fifo_continue=1, fifo_pause=0.
  - Memory contents are don't-care.
- init=1 at an edge (synchronous, overrides wr_en/rd_en):
  - Clears the same state as reset.
  - Loads the watermark registers from umbral_alto and umbral_bajo.
  - Takes effect even mid-stream; stored words are discarded.
- Write accepted when wr_en=1 and either (count<DEPTH) or (count==DEPTH and an accepted read in the same cycle).
  - Accepted write: mem[wr_ptr]<=data_in, then wr_ptr+1.
- Read accepted when rd_en=1 and count>0.
  - On the next edge, data_out<=mem[rd_ptr], rd_ptr+1 and valid_out=1.
  - Otherwise valid_out=0 and data_out holds its value.
  - Read latency: 1 cycle.
- Count update:
  - +1 on write only, -1 on read only.
  - Unchanged when both or neither are accepted.
- Empty FIFO with both wr_en and rd_en: the write is accepted, the read is ignored (no bypass), and count becomes 1.
- Full FIFO with both wr_en and rd_en: both are accepted, count stays DEPTH, no error.
- Overflow: wr_en=1, count==DEPTH and no accepted read.
  - The write is dropped and the pointers are unchanged.
  - fifo_error<=1 on that edge and stays 1 until reset or init.
- Underflow (rd_en with count==0) is ignored silently; no error, valid_out=0.
- Status flags are combinational decodes of the registered count and watermarks, so they reflect the post-edge occupancy in the same cycle.
  - Status outputs are glitch-free relative to clk consumers.
- Watermark edge cases:
  - umbral_alto=0 gives permanent pause.
  - umbral_alto>DEPTH means pause never asserts.
  - If umbral_bajo>=umbral_alto, both flags may be high together; this is legal, and the FSM resolves it in its pause-and-continue state.

Decomposition:
- Shared package tlp_pkg:
  - DATA_W, ADDR_W, DEPTH and the default watermark constants.
  - Number of lanes (4), so the FSM and the FIFOs agree.
- One natural sub-module, fifo_mem_2p: a dual-pointer register-array memory (write port plus registered read port).
  - fifo_flow_ctrl wraps it with the pointer, count, flag and error logic.

Test Plan:
- Reset then idle:
  - Stimulus: reset pulse, no traffic.
  - Required: fifo_empty=1, fifo_continue=1, fifo_pause=0, fifo_full=0, fifo_error=0, valid_out=0.
- Fill with default watermarks:
  - Stimulus: write 0x001..0x008 on consecutive cycles.
  - Required: fifo_continue drops after the 3rd write (count=3); fifo_pause rises after the 6th write; fifo_full rises after the 8th write; fifo_error stays 0.
- Overflow:
  - Stimulus: FIFO full, 9th write 0x3FF.
  - Required: fifo_error=1 and sticky.
  - Stimulus: then drain 8 words.
  - Required: data_out sequence 0x001..0x008 with 1-cycle latency; 0x3FF never appears; fifo_error still 1 until init.
- Simultaneous read and write:
  - Stimulus: count=8, wr_en=rd_en=1 for 4 cycles.
  - Required: count stays 8, no error, FIFO order preserved.
  - Stimulus: count=0, wr_en=rd_en=1 once.
  - Required: count=1, valid_out=0.
- Init reprogramming:
  - Stimulus: init with umbral_alto=4, umbral_bajo=1.
  - Required: FIFO cleared.
  - Stimulus: 4 writes.
  - Required: fifo_pause=1 at count 4.
  - Stimulus: 3 reads.
  - Required: fifo_continue=1 at count 1.
- Pointer wrap and async reset:
  - Stimulus: 20 interleaved write/read pairs.
  - Required: data integrity across pointer wrap.
  - Stimulus: reset asserted mid-cycle while count=5.
  - Required: outputs clear immediately without waiting for clk.
